// File: rtl/risc_top.sv
// risc_top: single-cycle RV32I core with separate instruction and data buses.
//
// Ports:
//   clk     system clock, all state updates on the rising edge
//   rst     asynchronous active-high reset
//   IAD     instruction address (registered PC)
//   IDT     instruction word, valid while ACKI_n = 0
//   ACKI_n  instruction acknowledge, active low
//   DAD     data byte address (rs1 + imm)
//   MREQ    data access request (load/store only)
//   WRITE   1 = store, 0 = load
//   SIZE    00 word, 01 halfword, 10 byte
//   DDT     bidirectional data bus, driven by the core only during stores
//   ACKD_n  data acknowledge, active low
//   OINT_n  external interrupt requests (unused)
//   IACK_n  interrupt acknowledge, tied inactive
//
// risc_datapath holds the architectural state (PC and register file rf) together with
// decode, ALU, branch and load/store formatting. The top only qualifies the bus outputs
// and owns the tristate data bus.

module risc_datapath (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] instr_i,
    input  logic        instr_vld_i,
    input  logic        dack_i,
    input  logic [31:0] load_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] dad_o,
    output logic        mreq_o,
    output logic        write_o,
    output logic [1:0]  size_o,
    output logic [31:0] store_data_o
);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpOpImm  = 7'b0010011;
    localparam logic [6:0] OpOp     = 7'b0110011;

    typedef enum logic [3:0] {
        AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd
    } alu_op_e;

    typedef enum logic [2:0] {WbAlu, WbLui, WbAuipc, WbPc4, WbLoad} wb_sel_e;

    logic [31:0] pc_q, pc_d;
    logic [31:0] rf [32];

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] rs1_val, rs2_val;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    alu_op_e     alu_op;
    wb_sel_e     wb_sel;
    logic        alu_use_imm, rf_we;
    logic        is_load, is_store, is_jal, is_jalr, is_branch;
    logic        br_cond;
    logic [31:0] alu_b, alu_res;
    logic [31:0] mem_addr, pc_plus4, load_val, wb_data, next_pc;
    logic        mem_op, commit;

    assign opcode = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign funct3 = instr_i[14:12];
    assign rs1    = instr_i[19:15];
    assign rs2    = instr_i[24:20];
    assign funct7 = instr_i[31:25];

    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                    instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'h000};
    assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                    instr_i[30:21], 1'b0};

    assign rs1_val = (rs1 == 5'd0) ? 32'h0 : rf[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'h0 : rf[rs2];

    // Decode. Anything not recognised falls through as a NOP (PC+4, no write, no access).
    always_comb begin
        alu_op      = AluAdd;
        alu_use_imm = 1'b0;
        wb_sel      = WbAlu;
        rf_we       = 1'b0;
        is_load     = 1'b0;
        is_store    = 1'b0;
        is_jal      = 1'b0;
        is_jalr     = 1'b0;
        is_branch   = 1'b0;
        case (opcode)
            OpLui: begin
                rf_we  = 1'b1;
                wb_sel = WbLui;
            end
            OpAuipc: begin
                rf_we  = 1'b1;
                wb_sel = WbAuipc;
            end
            OpJal: begin
                rf_we  = 1'b1;
                wb_sel = WbPc4;
                is_jal = 1'b1;
            end
            OpJalr: begin
                if (funct3 == 3'b000) begin
                    rf_we   = 1'b1;
                    wb_sel  = WbPc4;
                    is_jalr = 1'b1;
                end
            end
            OpBranch: begin
                is_branch = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            OpLoad: begin
                if (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
                    is_load = 1'b1;
                    rf_we   = 1'b1;
                    wb_sel  = WbLoad;
                end
            end
            OpStore: begin
                is_store = (funct3 inside {3'b000, 3'b001, 3'b010});
            end
            OpOpImm: begin
                alu_use_imm = 1'b1;
                rf_we       = 1'b1;
                case (funct3)
                    3'b000: alu_op = AluAdd;
                    3'b010: alu_op = AluSlt;
                    3'b011: alu_op = AluSltu;
                    3'b100: alu_op = AluXor;
                    3'b110: alu_op = AluOr;
                    3'b111: alu_op = AluAnd;
                    3'b001: begin
                        alu_op = AluSll;
                        rf_we  = (funct7 == 7'h00);
                    end
                    default: begin
                        alu_op = (funct7 == 7'h20) ? AluSra : AluSrl;
                        rf_we  = (funct7 == 7'h00) || (funct7 == 7'h20);
                    end
                endcase
            end
            OpOp: begin
                if (funct7 == 7'h00) begin
                    rf_we = 1'b1;
                    case (funct3)
                        3'b000:  alu_op = AluAdd;
                        3'b001:  alu_op = AluSll;
                        3'b010:  alu_op = AluSlt;
                        3'b011:  alu_op = AluSltu;
                        3'b100:  alu_op = AluXor;
                        3'b101:  alu_op = AluSrl;
                        3'b110:  alu_op = AluOr;
                        default: alu_op = AluAnd;
                    endcase
                end else if (funct7 == 7'h20 && funct3 == 3'b000) begin
                    rf_we  = 1'b1;
                    alu_op = AluSub;
                end else if (funct7 == 7'h20 && funct3 == 3'b101) begin
                    rf_we  = 1'b1;
                    alu_op = AluSra;
                end
            end
            default: ;
        endcase
    end

    assign alu_b = alu_use_imm ? imm_i : rs2_val;

    always_comb begin
        alu_res = 32'h0;
        unique case (alu_op)
            AluAdd:  alu_res = rs1_val + alu_b;
            AluSub:  alu_res = rs1_val - alu_b;
            AluSll:  alu_res = rs1_val << alu_b[4:0];
            AluSlt:  alu_res = {31'h0, $signed(rs1_val) < $signed(alu_b)};
            AluSltu: alu_res = {31'h0, rs1_val < alu_b};
            AluXor:  alu_res = rs1_val ^ alu_b;
            AluSrl:  alu_res = rs1_val >> alu_b[4:0];
            AluSra:  alu_res = $unsigned($signed(rs1_val) >>> alu_b[4:0]);
            AluOr:   alu_res = rs1_val | alu_b;
            AluAnd:  alu_res = rs1_val & alu_b;
            default: alu_res = 32'h0;
        endcase
    end

    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            3'b000:  br_cond = (rs1_val == rs2_val);
            3'b001:  br_cond = (rs1_val != rs2_val);
            3'b100:  br_cond = ($signed(rs1_val) < $signed(rs2_val));
            3'b101:  br_cond = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  br_cond = (rs1_val < rs2_val);
            3'b111:  br_cond = (rs1_val >= rs2_val);
            default: br_cond = 1'b0;
        endcase
    end

    // One adder serves both the data address and the JALR target.
    assign mem_addr = rs1_val + (is_store ? imm_s : imm_i);
    assign pc_plus4 = pc_q + 32'd4;

    // The memory returns narrow data zero-extended in the low lanes.
    always_comb begin
        load_val = load_data_i;
        case (funct3)
            3'b000:  load_val = {{24{load_data_i[7]}}, load_data_i[7:0]};
            3'b001:  load_val = {{16{load_data_i[15]}}, load_data_i[15:0]};
            3'b100:  load_val = {24'h0, load_data_i[7:0]};
            3'b101:  load_val = {16'h0, load_data_i[15:0]};
            default: load_val = load_data_i;
        endcase
    end

    always_comb begin
        wb_data = alu_res;
        case (wb_sel)
            WbLui:   wb_data = imm_u;
            WbAuipc: wb_data = pc_q + imm_u;
            WbPc4:   wb_data = pc_plus4;
            WbLoad:  wb_data = load_val;
            default: wb_data = alu_res;
        endcase
    end

    always_comb begin
        next_pc = pc_plus4;
        if (is_jal) begin
            next_pc = pc_q + imm_j;
        end else if (is_jalr) begin
            next_pc = {mem_addr[31:1], 1'b0};
        end else if (is_branch && br_cond) begin
            next_pc = pc_q + imm_b;
        end
    end

    // An instruction retires when fetched and, for memory ops, acknowledged.
    assign mem_op = is_load || is_store;
    assign commit = instr_vld_i && (!mem_op || dack_i);
    assign pc_d   = commit ? next_pc : pc_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= 32'h0;
        end else begin
            pc_q <= pc_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= 32'h0;
            end
        end else if (commit && rf_we && (rd != 5'd0)) begin
            rf[rd] <= wb_data;
        end
    end

    assign pc_o         = pc_q;
    assign dad_o        = mem_addr;
    assign mreq_o       = instr_vld_i && mem_op;
    assign write_o      = is_store;
    assign size_o       = (funct3[1:0] == 2'b00) ? 2'b10 :
                          (funct3[1:0] == 2'b01) ? 2'b01 : 2'b00;
    assign store_data_o = rs2_val;

endmodule

module risc_top (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] IAD,
    input  logic [31:0] IDT,
    input  logic        ACKI_n,
    output logic [31:0] DAD,
    output logic        MREQ,
    output logic        WRITE,
    output logic [1:0]  SIZE,
    inout  wire  [31:0] DDT,
    input  logic        ACKD_n,
    input  logic [2:0]  OINT_n,
    output logic        IACK_n
);

    logic        mreq_raw, write_raw;
    logic [1:0]  size_raw;
    logic [31:0] store_data;
    logic        unused_oint;

    assign unused_oint = ^OINT_n;

    risc_datapath datapath (
        .clk_i        (clk),
        .rst_i        (rst),
        .instr_i      (IDT),
        .instr_vld_i  (!ACKI_n),
        .dack_i       (!ACKD_n),
        .load_data_i  (DDT),
        .pc_o         (IAD),
        .dad_o        (DAD),
        .mreq_o       (mreq_raw),
        .write_o      (write_raw),
        .size_o       (size_raw),
        .store_data_o (store_data)
    );

    // Bus qualifiers are forced idle while reset is asserted.
    assign MREQ   = mreq_raw && !rst;
    assign WRITE  = MREQ && write_raw;
    assign SIZE   = MREQ ? size_raw : 2'b00;
    assign DDT    = WRITE ? store_data : 32'bz;
    assign IACK_n = 1'b1;

endmodule

// File: tb/tb_risc_top.sv
// Bench for risc_top: acts as instruction/data memory with random acknowledge stalls and
// compares the core against an instruction-level reference model every cycle.

module tb_risc_top;

    logic        clk, rst;
    logic [31:0] iad, idt, dad;
    logic        acki_n, ackd_n, mreq, wr, iack_n;
    logic [1:0]  size;
    logic [2:0]  oint_n;
    wire  [31:0] ddt;
    logic [31:0] rdata;
    logic        rd_en;

    assign ddt = rd_en ? rdata : 32'bz;

    risc_top dut (
        .clk    (clk),
        .rst    (rst),
        .IAD    (iad),
        .IDT    (idt),
        .ACKI_n (acki_n),
        .DAD    (dad),
        .MREQ   (mreq),
        .WRITE  (wr),
        .SIZE   (size),
        .DDT    (ddt),
        .ACKD_n (ackd_n),
        .OINT_n (oint_n),
        .IACK_n (iack_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Shared instruction memory, bus-side data memory and model-side data memory.
    logic [31:0] imem [256];
    logic [7:0]  bus_mem [1024];
    logic [7:0]  m_mem [1024];
    logic [7:0]  stdout_byte;
    bit          exit_seen;

    // Reference model state and the current instruction's expected bus activity.
    logic [31:0] m_pc;
    logic [31:0] m_regs [32];
    bit          e_mem, e_wr, e_we;
    logic [1:0]  e_size;
    logic [31:0] e_addr, e_sdata, e_npc, e_wb;
    logic [4:0]  e_rd;

    function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                          logic [4:0] rd, logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction
    function automatic logic [31:0] enc_u(logic [19:0] imm, logic [4:0] rd, logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [7:0] m_rd8(logic [31:0] a);
        return (a[31:24] == 8'h08) ? m_mem[a[9:0]] : 8'h00;
    endfunction
    function automatic logic [7:0] bus_rd8(logic [31:0] a);
        return (a[31:24] == 8'h08) ? bus_mem[a[9:0]] : 8'h00;
    endfunction

    function automatic logic [31:0] bus_read(logic [31:0] a, logic [1:0] sz);
        if (sz == 2'b10) return {24'h0, bus_rd8(a)};
        if (sz == 2'b01) return {16'h0, bus_rd8(a + 1), bus_rd8(a)};
        return {bus_rd8(a + 3), bus_rd8(a + 2), bus_rd8(a + 1), bus_rd8(a)};
    endfunction

    function automatic logic [31:0] sz_mask(logic [1:0] sz);
        return (sz == 2'b10) ? 32'h0000_00FF : (sz == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] isa_alu(logic [2:0] f3, bit alt, logic [31:0] a,
                                            logic [31:0] b);
        int unsigned sh = b[4:0];
        case (f3)
            3'd0:    return alt ? a - b : a + b;
            3'd1:    return a << sh;
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return alt ? $unsigned($signed(a) >>> sh) : a >> sh;
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    // Interpret the instruction at the model PC (RV32I semantics).
    task automatic model_decode();
        logic [31:0] ins, a, b, ii, si, bi, ui, ji, lw;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        bit          tk;
        ins = imem[m_pc[9:2]];
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        a = m_regs[ins[19:15]]; b = m_regs[ins[24:20]];
        ii = {{20{ins[31]}}, ins[31:20]};
        si = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        bi = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        ui = {ins[31:12], 12'h0};
        ji = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        e_rd = ins[11:7]; e_npc = m_pc + 4; e_we = 0; e_wb = 0;
        e_mem = 0; e_wr = 0; e_size = 2'b00; e_addr = 0; e_sdata = 0;
        case (op)
            7'h37: begin e_we = 1; e_wb = ui; end
            7'h17: begin e_we = 1; e_wb = m_pc + ui; end
            7'h6F: begin e_we = 1; e_wb = m_pc + 4; e_npc = m_pc + ji; end
            7'h67: if (f3 == 0) begin e_we = 1; e_wb = m_pc + 4; e_npc = (a + ii) & ~32'd1; end
            7'h63: begin
                case (f3)
                    3'd0: tk = (a == b);
                    3'd1: tk = (a != b);
                    3'd4: tk = ($signed(a) < $signed(b));
                    3'd5: tk = ($signed(a) >= $signed(b));
                    3'd6: tk = (a < b);
                    3'd7: tk = (a >= b);
                    default: tk = 0;
                endcase
                if (tk) e_npc = m_pc + bi;
            end
            7'h03: if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
                e_mem = 1; e_addr = a + ii; e_we = 1;
                e_size = (f3[1:0] == 0) ? 2'b10 : (f3[1:0] == 1) ? 2'b01 : 2'b00;
                lw = {m_rd8(e_addr + 3), m_rd8(e_addr + 2), m_rd8(e_addr + 1), m_rd8(e_addr)};
                case (f3)
                    3'd0:    e_wb = {{24{lw[7]}}, lw[7:0]};
                    3'd1:    e_wb = {{16{lw[15]}}, lw[15:0]};
                    3'd4:    e_wb = {24'h0, lw[7:0]};
                    3'd5:    e_wb = {16'h0, lw[15:0]};
                    default: e_wb = lw;
                endcase
            end
            7'h23: if (f3 < 3) begin
                e_mem = 1; e_wr = 1; e_addr = a + si; e_sdata = b;
                e_size = (f3 == 0) ? 2'b10 : (f3 == 1) ? 2'b01 : 2'b00;
            end
            7'h13: if (!((f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 7'h20))) begin
                e_we = 1; e_wb = isa_alu(f3, (f3 == 5) && f7[5], a, ii);
            end
            7'h33: if (f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))) begin
                e_we = 1; e_wb = isa_alu(f3, f7[5], a, b);
            end
            default: ;
        endcase
    endtask

    task automatic model_commit();
        int nb;
        if (e_mem && e_wr && e_addr[31:24] == 8'h08) begin
            nb = (e_size == 2'b10) ? 1 : (e_size == 2'b01) ? 2 : 4;
            for (int k = 0; k < nb; k++) m_mem[10'(e_addr + k)] = e_sdata[8*k +: 8];
        end
        if (e_we && e_rd != 0) m_regs[e_rd] = e_wb;
        m_pc = e_npc;
    endtask

    task automatic bus_store();
        int nb = (size == 2'b10) ? 1 : (size == 2'b01) ? 2 : 4;
        if (dad[31:24] == 8'h08) begin
            for (int k = 0; k < nb; k++) bus_mem[10'(dad + k)] = ddt[8*k +: 8];
        end
        if (dad == 32'hF000_0000) stdout_byte = ddt[7:0];
        if (dad == 32'hFF00_0000) exit_seen = 1;
    endtask

    // Asserts reset mid-cycle, checks the reset outputs, returns at a falling edge.
    task automatic reset_pulse();
        #3 rst = 1;
        #1;
        check_eq("rst_iad", iad, 32'h0);
        check_eq("rst_mreq", {31'h0, mreq}, 32'h0);
        check_eq("rst_write", {31'h0, wr}, 32'h0);
        check_eq("rst_size", {30'h0, size}, 32'h0);
        check_eq("rst_iack", {31'h0, iack_n}, 32'h1);
        m_pc = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    int lw_stall;

    // Runs n cycles; entered and left at a falling edge.
    task automatic run_cycles(input int n, input bit directed);
        bit cmt;
        for (int c = 0; c < n; c++) begin
            model_decode();
            acki_n = ($urandom_range(0, 4) == 0);
            ackd_n = ($urandom_range(0, 2) == 0);
            if (directed && m_pc == 32'h54 && !acki_n && lw_stall < 2) begin
                ackd_n = 1;
                lw_stall++;
            end
            idt = acki_n ? $urandom : imem[iad[9:2]];
            #1;
            rdata = bus_read(dad, size);
            rd_en = mreq && !wr;
            #1;
            check_eq("iad", iad, m_pc);
            check_eq("mreq", {31'h0, mreq}, {31'h0, !acki_n && e_mem});
            if (!acki_n && e_mem) begin
                check_eq("dad", dad, e_addr);
                check_eq("write", {31'h0, wr}, {31'h0, e_wr});
                check_eq("size", {30'h0, size}, {30'h0, e_size});
                if (e_wr) check_eq("ddt", ddt & sz_mask(e_size), e_sdata & sz_mask(e_size));
            end
            for (int i = 0; i < 32; i++) check_eq($sformatf("x%0d", i), dut.datapath.rf[i],
                                                  m_regs[i]);
            if (mreq && wr && !ackd_n) bus_store();
            cmt = !acki_n && (!e_mem || !ackd_n);
            @(posedge clk);
            if (cmt) model_commit();
            @(negedge clk);
            rd_en = 0;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd = 5'($urandom_range(1, 30));
        logic [4:0]  rs1 = 5'($urandom_range(0, 31));
        logic [4:0]  rs2 = 5'($urandom_range(0, 31));
        logic [2:0]  f3 = 3'($urandom_range(0, 7));
        logic [11:0] imm = 12'($urandom);
        logic [2:0]  ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic [2:0]  br_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        logic [11:0] off;
        case ($urandom_range(0, 9))
            0, 1: begin
                if (f3 == 1) imm[11:5] = 7'h00;
                if (f3 == 5) imm[11:5] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
                return enc_i(imm, rs1, f3, rd, 7'h13);
            end
            2, 3: return {((f3 == 0 || f3 == 5) && $urandom_range(0, 1)) ? 7'h20 : 7'h00,
                          rs2, rs1, f3, rd, 7'h33};
            4: return enc_u(20'($urandom), rd, $urandom_range(0, 1) ? 7'h37 : 7'h17);
            5: begin
                f3 = ld_f3[$urandom_range(0, 4)];
                off = (f3[1:0] == 2) ? 12'($urandom_range(0, 63) * 4) :
                      (f3[1:0] == 1) ? 12'($urandom_range(0, 127) * 2) :
                      12'($urandom_range(0, 255));
                return enc_i(off, 5'd31, f3, rd, 7'h03);
            end
            6: begin
                f3 = 3'($urandom_range(0, 2));
                off = (f3 == 2) ? 12'($urandom_range(0, 63) * 4) :
                      (f3 == 1) ? 12'($urandom_range(0, 127) * 2) : 12'($urandom_range(0, 255));
                return enc_s(off, rs2, 5'd31, f3);
            end
            7: return enc_b(13'($urandom_range(1, 3) * 4), rs2, rs1, br_f3[$urandom_range(0, 5)]);
            8: return enc_j(21'($urandom_range(2, 3) * 4), rd);
            default: begin
                case ($urandom_range(0, 4))
                    0: return 32'h0000_000F;
                    1: return 32'h0000_0073;
                    2: return 32'h0010_0073;
                    3: return {7'h01, rs2, rs1, f3, rd, 7'h33};
                    default: return {25'($urandom), 7'h7F};
                endcase
            end
        endcase
    endfunction

    initial begin
        rst = 1; acki_n = 1; ackd_n = 1; idt = 0; rdata = 0; rd_en = 0; oint_n = 3'b111;
        stdout_byte = 0; exit_seen = 0; lw_stall = 0;
        for (int i = 0; i < 256; i++) imem[i] = 32'h0000_006F;
        for (int i = 0; i < 1024; i++) begin bus_mem[i] = 0; m_mem[i] = 0; end

        // Directed program.
        imem[0]  = enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13);
        imem[1]  = enc_i(12'hFF9, 5'd1, 3'd0, 5'd2, 7'h13);
        imem[2]  = enc_u(20'h08000, 5'd3, 7'h37);
        imem[3]  = enc_s(12'd0, 5'd2, 5'd3, 3'd2);
        imem[4]  = enc_i(12'd0, 5'd3, 3'd0, 5'd4, 7'h03);
        imem[5]  = enc_i(12'd0, 5'd3, 3'd4, 5'd5, 7'h03);
        imem[6]  = enc_b(13'd8, 5'd1, 5'd2, 3'd4);
        imem[7]  = enc_i(12'd1, 5'd0, 3'd0, 5'd6, 7'h13);
        imem[8]  = enc_j(21'd16, 5'd1);
        imem[9]  = enc_b(13'd8, 5'd1, 5'd2, 3'd6);
        imem[10] = enc_j(21'h16, 5'd0);
        imem[12] = enc_i(12'd3, 5'd1, 3'd0, 5'd0, 7'h67);
        imem[16] = enc_i(12'h041, 5'd0, 3'd0, 5'd8, 7'h13);
        imem[17] = enc_u(20'hF0000, 5'd9, 7'h37);
        imem[18] = enc_s(12'd0, 5'd8, 5'd9, 3'd0);
        imem[19] = enc_u(20'hFF000, 5'd10, 7'h37);
        imem[20] = enc_s(12'd0, 5'd0, 5'd10, 3'd2);
        imem[21] = enc_i(12'd0, 5'd3, 3'd2, 5'd11, 7'h03);
        imem[22] = enc_u(20'h00001, 5'd0, 7'h37);

        @(negedge clk);
        reset_pulse();
        run_cycles(160, 1);
        check_eq("d_x1", dut.datapath.rf[1], 32'h0000_0024);
        check_eq("d_x2", dut.datapath.rf[2], 32'hFFFF_FFFE);
        check_eq("d_x4", dut.datapath.rf[4], 32'hFFFF_FFFE);
        check_eq("d_x5", dut.datapath.rf[5], 32'h0000_00FE);
        check_eq("d_x6", dut.datapath.rf[6], 32'h0);
        check_eq("d_x11", dut.datapath.rf[11], 32'hFFFF_FFFE);
        check_eq("d_x0", dut.datapath.rf[0], 32'h0);
        check_eq("d_pc_end", iad, 32'h0000_005C);
        check_eq("d_stdout", {24'h0, stdout_byte}, 32'h41);
        check_eq("d_exit", {31'h0, exit_seen}, 32'h1);
        check_eq("d_lw_stalls", lw_stall, 2);

        // Random programs, each interrupted once by a mid-run reset.
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 256; i++) imem[i] = 32'h0000_006F;
            for (int i = 0; i < 1024; i++) begin bus_mem[i] = 0; m_mem[i] = 0; end
            imem[0] = enc_u(20'h08000, 5'd31, 7'h37);
            for (int i = 1; i <= 150; i++) imem[i] = rand_instr();
            reset_pulse();
            run_cycles(80, 0);
            reset_pulse();
            run_cycles(700, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
